sample_sched: RTL
=================

Name: sample_sched

Overview:
- Sequences the sample-test datapath for one triangle at a time.
- Accepts a triangle plus its bounding box from the bbox stage, walks the box in raster order, and emits one group of SAMPS sample locations per cycle with per-sample valid flags.
- Sits between bbox and the sample-test stage and owns the upstream halt and downstream stall handshakes.

Parameters:
- SIGFIG, 24, bits in position/color fixed-point words
- RADIX, 10, fraction bits
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, color channels
- SAMPS, 4, samples issued per group (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- tri_R13S  in  [VERTS][AXIS] x SIGFIG signed  triangle vertices
- color_R13U  in  [COLORS] x SIGFIG unsigned  triangle color
- box_R13S  in  [2][2] x SIGFIG signed  bbox; [0]=lower-left (x,y), [1]=upper-right (x,y), inclusive
- step_R13U  in  SIGFIG unsigned  sample pitch in fixed point
- validTri_R13H  in  1  triangle/bbox valid
- stall_R14H  in  1  downstream cannot accept this cycle
- halt_R13H  out  1  upstream must hold its triangle
- tri_R14S  out  [VERTS][AXIS] x SIGFIG signed  latched triangle
- color_R14U  out  [COLORS] x SIGFIG unsigned  latched color
- sample_R14S  out  [2][SAMPS] x SIGFIG signed  sample x/y per lane
- validSamp_R14H  out  [SAMPS] x 1  lane valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: state=IDLE; all registered outputs 0. halt_R13H then evaluates to stall_R14H. Asserting rst mid-triangle aborts it; no partial groups are emitted after release.
- halt_R13H = (state==RUN) | stall_R14H. This is combinational from the state register and the stall input.
- Accept: a triangle is accepted on a clk edge when validTri_R13H=1 and halt_R13H=0. On accept, latch tri, color, bbox, and eff_step, where eff_step = step_R13U, or (1<<RADIX) when step_R13U=0. Initialise cur_x=box[0].x, cur_y=box[0].y.
- Empty box: if box[0].x>box[1].x or box[0].y>box[1].y at accept, the triangle is consumed, state stays IDLE, and no group is emitted.
- FSM: two states.
  - IDLE -> RUN on accept of a non-empty box.
  - RUN -> IDLE on the edge that issues the final group.
- Stall: while stall_R14H=1, every output register, cur_x/cur_y and the state hold. There is no accept and no advance.
- RUN with stall=0, each edge registers one group. For lane k in 0..SAMPS-1:
  - sample_R14S[0][k] = cur_x + k*eff_step
  - sample_R14S[1][k] = cur_y
  - validSamp_R14H[k] = (cur_x + k*eff_step <= box[1].x)
  - tri_R14S and color_R14U carry the latched values.
- Advance (RUN, stall=0):
  - If cur_x + SAMPS*eff_step <= box[1].x: cur_x += SAMPS*eff_step.
  - Else if cur_y + eff_step <= box[1].y: cur_x = box[0].x and cur_y += eff_step.
  - Else the current group is the final one: go to IDLE.
- Arithmetic: all sums and compares use signed SIGFIG+log2(SAMPS)+2 bit intermediates, so no wrap occurs. Sample outputs are truncated to SIGFIG; in-box samples always fit.
- Latency: the first group is registered on the edge after accept. Groups are then continuous at one per non-stalled cycle.
- IDLE with stall=0: validSamp_R14H all 0, other outputs hold.
- Back-to-back triangles: the earliest next accept is the edge after the final group, because halt drops when state returns to IDLE. This gives one bubble per triangle.
- Simultaneous events:
  - stall=1 together with validTri=1 in IDLE gives no accept.
  - The final-group edge cannot also accept, because halt was high during it.

Test Plan:
- Single row, RADIX=10, SAMPS=4, step=1024, box (0,0)-(5120,0), no stall -> 2 groups:
  - x {0,1024,2048,3072} valid 1111
  - x {4096,5120,6144,7168} valid 0011
  - halt high for exactly 2 cycles, then IDLE.
- Two rows, box (0,0)-(3072,1024) -> 2 groups, y=0 then y=1024, each all-valid. The triangle and color outputs equal the latched input on both groups.
- Stall mid-triangle: assert stall_R14H for 3 cycles after the first group -> outputs frozen for 3 cycles, then resume with no group lost or duplicated.
- Empty box (ll.x=2048 > ur.x=1024) with validTri -> accepted, no validSamp asserted, halt never rises from state.
- step_R13U=0, box (0,0)-(1024,0) -> behaves as step=1024: one group {0,1024,2048,3072}, valid 0011.
- Async reset (rst=0) asserted during RUN in the second row -> all outputs 0 immediately. After release, a new triangle is accepted and processed normally.

Source files
------------

// File: rtl/sample_sched_if.sv
// sample_sched_if: triangle/bbox in, sample group out, halt/stall handshakes.
interface sample_sched_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
);
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_r13s;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_r14s;
  logic [COLORS-1:0][SIGFIG-1:0] color_r13u;
  logic [COLORS-1:0][SIGFIG-1:0] color_r14u;
  logic signed [1:0][1:0][SIGFIG-1:0] box_r13s;
  logic [SIGFIG-1:0] step_r13u;
  logic valid_tri_r13h;
  logic stall_r14h;
  logic halt_r13h;
  logic signed [1:0][SAMPS-1:0][SIGFIG-1:0] sample_r14s;
  logic [SAMPS-1:0] valid_samp_r14h;
  modport master (
    output tri_r13s, color_r13u, box_r13s, step_r13u, valid_tri_r13h, stall_r14h,
    input  halt_r13h, tri_r14s, color_r14u, sample_r14s, valid_samp_r14h
  );
  modport slave (
    input  tri_r13s, color_r13u, box_r13s, step_r13u, valid_tri_r13h, stall_r14h,
    output halt_r13h, tri_r14s, color_r14u, sample_r14s, valid_samp_r14h
  );
endinterface

// File: rtl/sample_sched.sv
// sample_sched: walks a triangle's bbox in raster order, issuing SAMPS samples per cycle.
module sample_sched #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
) (
  input logic clk,
  input logic rst_n,
  sample_sched_if.slave s
);
  localparam int W = SIGFIG + $clog2(SAMPS) + 2;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0] state;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
  logic [COLORS-1:0][SIGFIG-1:0] color_q;
  logic signed [W-1:0] llx, urx, ury, step_q, cur_x, cur_y;
  logic signed [W-1:0] in_llx, in_lly, in_urx, in_ury, in_step;
  logic signed [W-1:0] lx [SAMPS+1];
  logic [SIGFIG-1:0] step_in;
  function automatic logic signed [W-1:0] sx(input logic [SIGFIG-1:0] v);
    return {{(W-SIGFIG){v[SIGFIG-1]}}, v};
  endfunction
  assign s.halt_r13h = (state == RUN) | s.stall_r14h;
  assign in_llx  = sx(s.box_r13s[0][0]);
  assign in_lly  = sx(s.box_r13s[0][1]);
  assign in_urx  = sx(s.box_r13s[1][0]);
  assign in_ury  = sx(s.box_r13s[1][1]);
  assign step_in = (s.step_r13u == '0) ? SIGFIG'(1 << RADIX) : s.step_r13u;
  assign in_step = {{(W-SIGFIG){1'b0}}, step_in};
  // lx[SAMPS] is the x of the next group on this row
  always_comb begin
    lx[0] = cur_x;
    for (int k = 1; k <= SAMPS; k++) lx[k] = lx[k-1] + step_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tri_q <= '0;
      color_q <= '0;
      llx <= '0;
      urx <= '0;
      ury <= '0;
      step_q <= '0;
      cur_x <= '0;
      cur_y <= '0;
      s.tri_r14s <= '0;
      s.color_r14u <= '0;
      s.sample_r14s <= '0;
      s.valid_samp_r14h <= '0;
    end else if (!s.stall_r14h) begin
      if (state == RUN) begin
        s.tri_r14s <= tri_q;
        s.color_r14u <= color_q;
        for (int k = 0; k < SAMPS; k++) begin
          s.sample_r14s[0][k] <= lx[k][SIGFIG-1:0];
          s.sample_r14s[1][k] <= cur_y[SIGFIG-1:0];
          s.valid_samp_r14h[k] <= (lx[k] <= urx);
        end
        if (lx[SAMPS] <= urx) cur_x <= lx[SAMPS];
        else if (cur_y + step_q <= ury) begin
          cur_x <= llx;
          cur_y <= cur_y + step_q;
        end else state <= IDLE;
      end else begin
        s.valid_samp_r14h <= '0;
        if (s.valid_tri_r13h) begin
          tri_q <= s.tri_r13s;
          color_q <= s.color_r13u;
          llx <= in_llx;
          urx <= in_urx;
          ury <= in_ury;
          step_q <= in_step;
          cur_x <= in_llx;
          cur_y <= in_lly;
          state <= (in_llx > in_urx || in_lly > in_ury) ? IDLE : RUN;
        end
      end
    end
  end
endmodule
